// File: rtl/ring_ni_tx_if.sv
// Core-request and router-injection signals of the ring network-interface transmitter.
interface ring_ni_tx_if #(
    parameter int unsigned PLD_BYTES = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_dst;
    logic [8*PLD_BYTES-1:0] req_data;
    logic                   fifo_full;
    logic [7:0]             flit_out;
    logic                   flit_wr;

    // Transmitter side: takes core requests, drives flits into the router FIFO.
    modport master (
        input  req_valid, req_dst, req_data, fifo_full,
        output req_ready, flit_out, flit_wr
    );

    // Environment side: the local core plus the router input FIFO.
    modport slave (
        output req_valid, req_dst, req_data, fifo_full,
        input  req_ready, flit_out, flit_wr
    );
endinterface

// File: rtl/ring_ni_tx.sv
// Ring node transmitter: packetizes {dst, payload} messages into one header flit
// followed by PLD_BYTES body flits (LSB byte first) and injects them into the router FIFO.
module ring_ni_tx #(
    parameter int unsigned NODE_ID   = 0,
    parameter int unsigned NUM_NODES = 3,
    parameter int unsigned PLD_BYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    ring_ni_tx_if.master        bus,
    output logic                err_dst,
    output logic                busy,
    output logic [15:0]         pkt_cnt
);
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned DATA_W = 8 * PLD_BYTES;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          dst_q;
    logic [DATA_W-1:0]   data_q;
    logic [IDX_W-1:0]    idx_q;

    logic                last_c;
    logic                wr_c;
    logic                ready_c;
    logic                legal_c;
    logic [7:0]          header_c;
    logic [7:0]          body_c;

    // Flit selection and handshakes, all derived from registered state and fifo_full.
    assign last_c   = (idx_q == IDX_W'(PLD_BYTES - 1));
    assign wr_c     = ((state == HDR) || (state == BODY)) && !bus.fifo_full;
    assign ready_c  = (state == IDLE) || ((state == BODY) && last_c && !bus.fifo_full);
    assign legal_c  = ({1'b0, bus.req_dst} < 3'(NUM_NODES));
    assign header_c = {dst_q, 2'(NODE_ID), 4'(PLD_BYTES)};
    assign body_c   = 8'(data_q >> {idx_q, 3'b000});

    assign bus.flit_wr   = wr_c;
    assign bus.req_ready = ready_c;
    assign bus.flit_out  = (state == HDR)  ? header_c :
                           (state == BODY) ? body_c   : 8'h00;
    assign busy          = (state != IDLE);

    // Packet sequencer: message latch, byte index, drop pulse and packet counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dst_q   <= 2'd0;
            data_q  <= '0;
            idx_q   <= '0;
            err_dst <= 1'b0;
            pkt_cnt <= 16'd0;
        end else begin
            err_dst <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        if (legal_c) begin
                            dst_q  <= bus.req_dst;
                            data_q <= bus.req_data;
                            state  <= HDR;
                        end else begin
                            err_dst <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (!bus.fifo_full) begin
                        idx_q <= '0;
                        state <= BODY;
                    end
                end
                BODY: begin
                    if (!bus.fifo_full) begin
                        if (last_c) begin
                            pkt_cnt <= pkt_cnt + 16'd1;
                            idx_q   <= '0;
                            state   <= IDLE;
                            // Back-to-back message accepted on the final body write.
                            if (bus.req_valid) begin
                                if (legal_c) begin
                                    dst_q  <= bus.req_dst;
                                    data_q <= bus.req_data;
                                    state  <= HDR;
                                end else begin
                                    err_dst <= 1'b1;
                                end
                            end
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ring_ni_tx.sv
// Scoreboard bench for ring_ni_tx: stimulus pushes expected flits, a monitor pops on each write.
module tb_ring_ni_tx;
    localparam int unsigned PLD_BYTES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        err_dst;
    logic        busy;
    logic [15:0] pkt_cnt;

    ring_ni_tx_if #(.PLD_BYTES(PLD_BYTES)) bus ();

    ring_ni_tx #(
        .NODE_ID  (0),
        .NUM_NODES(3),
        .PLD_BYTES(PLD_BYTES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus.master),
        .err_dst(err_dst),
        .busy   (busy),
        .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned writes      = 0;
    int unsigned run         = 0;
    int unsigned max_run     = 0;
    int unsigned err_pulses  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_flit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write is compared against the head of the expected-flit queue.
    always @(negedge clk) begin
        if (bus.flit_wr === 1'b1) begin
            writes++;
            run++;
            if (run > max_run) max_run = run;
            check("no_write_when_full", 32'(bus.fifo_full), 32'd0);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_flit: got %0h, expected no write (t=%0t)", bus.flit_out, $time);
            end else begin
                exp_flit = exp_q.pop_front();
                check("flit", 32'(bus.flit_out), 32'(exp_flit));
            end
        end else begin
            run = 0;
        end
        if (err_dst === 1'b1) err_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [1:0] dst, input logic [31:0] d);
        exp_q.push_back({dst, 2'd0, 4'd4});
        for (int i = 0; i < 4; i++) exp_q.push_back(d[8*i +: 8]);
    endtask

    // Present a message and wait (bounded) until req_ready is high; handshake happens on the next edge.
    task automatic wait_ready(input logic [1:0] dst, input logic [31:0] d);
        bus.req_valid = 1'b1;
        bus.req_dst   = dst;
        bus.req_data  = d;
        for (int n = 0; n < 50 && bus.req_ready !== 1'b1; n++) tick();
        if (bus.req_ready !== 1'b1) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic accept(input logic [1:0] dst, input logic [31:0] d);
        wait_ready(dst, d);
        tick();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && (busy !== 1'b0 || exp_q.size() != 0); n++) tick();
        tick();
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bus.req_valid = 1'b0;
        bus.req_dst   = 2'd0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_flit_wr",  32'(bus.flit_wr),  32'd0);
        check("rst_flit_out", 32'(bus.flit_out), 32'd0);
        check("rst_err_dst",  32'(err_dst),      32'd0);
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_pkt_cnt",  32'(pkt_cnt),      32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single unstalled packet to node 2
        writes = 0;
        push_pkt(2'd2, 32'hDDCCBBAA);
        accept(2'd2, 32'hDDCCBBAA);
        bus.req_valid = 1'b0;
        bus.req_data  = 32'hFFFFFFFF;
        b = 0;
        for (int k = 0; k < 8; k++) begin
            if (busy === 1'b1) b++;
            tick();
        end
        check("t1_busy_cycles", 32'(b), 32'd5);
        wait_idle();
        check("t1_writes",  32'(writes),  32'd5);
        check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // 2: three-cycle stall on the BB flit
        writes = 0;
        push_pkt(2'd2, 32'hDDCCBBAA);
        accept(2'd2, 32'hDDCCBBAA);
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("t2_pre_stall_out", 32'(bus.flit_out), 32'hBB);
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t2_stall_wr",  32'(bus.flit_wr),   32'd0);
            check("t2_stall_out", 32'(bus.flit_out),  32'hBB);
            check("t2_stall_rdy", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.fifo_full = 1'b0;
        wait_idle();
        check("t2_writes",  32'(writes),  32'd5);
        check("t2_pkt_cnt", 32'(pkt_cnt), 32'd2);

        // 3: back-to-back packets with req_valid held
        writes  = 0;
        max_run = 0;
        push_pkt(2'd0, 32'h0D0C0B0A);
        push_pkt(2'd1, 32'h44332211);
        accept(2'd0, 32'h0D0C0B0A);
        wait_ready(2'd1, 32'h44332211);
        check("t3_ready_in_body", 32'(busy), 32'd1);
        check("t3_last_body_out", 32'(bus.flit_out), 32'h0D);
        tick();
        bus.req_valid = 1'b0;
        wait_idle();
        check("t3_writes",  32'(writes),  32'd10);
        check("t3_max_run", 32'(max_run), 32'd10);
        check("t3_pkt_cnt", 32'(pkt_cnt), 32'd4);

        // 4: illegal destination is dropped with an error pulse
        writes     = 0;
        err_pulses = 0;
        accept(2'd3, 32'h12345678);
        bus.req_valid = 1'b0;
        check("t4_err_set", 32'(err_dst), 32'd1);
        tick();
        check("t4_err_clr", 32'(err_dst), 32'd0);
        tick();
        tick();
        check("t4_writes",     32'(writes),     32'd0);
        check("t4_err_pulses", 32'(err_pulses), 32'd1);
        check("t4_pkt_cnt",    32'(pkt_cnt),    32'd4);
        check("t4_busy",       32'(busy),       32'd0);

        // 5: reset after two body flits, then a fresh packet
        writes = 0;
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h88);
        exp_q.push_back(8'h77);
        accept(2'd1, 32'h55667788);
        bus.req_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("t5_rst_wr",      32'(bus.flit_wr),  32'd0);
        check("t5_rst_out",     32'(bus.flit_out), 32'd0);
        check("t5_rst_busy",    32'(busy),         32'd0);
        check("t5_rst_pkt_cnt", 32'(pkt_cnt),      32'd0);
        check("t5_rst_err",     32'(err_dst),      32'd0);
        check("t5_writes",      32'(writes),       32'd3);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_queue_empty", 32'(exp_q.size()), 32'd0);
        push_pkt(2'd2, 32'h01020304);
        accept(2'd2, 32'h01020304);
        bus.req_valid = 1'b0;
        wait_idle();
        check("t5_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // 6: packet counter wraps from FFFF to 0
        force dut.pkt_cnt = 16'hFFFF;
        tick();
        release dut.pkt_cnt;
        tick();
        check("t6_preset", 32'(pkt_cnt), 32'hFFFF);
        push_pkt(2'd0, 32'h11111111);
        accept(2'd0, 32'h11111111);
        bus.req_valid = 1'b0;
        wait_idle();
        check("t6_wrap", 32'(pkt_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
